// File: rtl/mult_pkg.sv
// Shared types and mux-select encodings for the repeated-addition multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic B_SEL_IN   = 1'b0;
  localparam logic B_SEL_SUB  = 1'b1;
  localparam logic M_SEL_ZERO = 1'b0;
  localparam logic M_SEL_ADD  = 1'b1;

endpackage

// File: rtl/mult_ctrl_if.sv
// Controller-side bus of the multiplier: operand/result handshakes,
// datapath enables/selects, the B_zero status flag and the cycle count.
interface mult_ctrl_if #(parameter int w = 16);

  logic         operands_val;
  logic         operands_rdy;
  logic         operand_b_zero;
  logic         result_val;
  logic         result_rdy;
  logic         A_en;
  logic         B_en;
  logic         M_en;
  logic         B_mux_sel;
  logic         M_mux_sel;
  logic         B_zero;
  logic [w-1:0] cycles;

  // Environment side: producer/consumer plus datapath.
  modport master (
    output operands_val, operand_b_zero, result_rdy, B_zero,
    input  operands_rdy, result_val, A_en, B_en, M_en,
           B_mux_sel, M_mux_sel, cycles
  );

  // Controller side.
  modport slave (
    input  operands_val, operand_b_zero, result_rdy, B_zero,
    output operands_rdy, result_val, A_en, B_en, M_en,
           B_mux_sel, M_mux_sel, cycles
  );

endinterface

// File: rtl/mult_ctrl_sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int w = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [w-1:0] o_cnt
);

  logic [w-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (i_clr)                   r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))  r_cnt <= r_cnt + w'(1);
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mult_ctrl.sv
// Repeated-addition multiplier controller: IDLE accepts operands, CALC does
// one M+=A / B-=1 step per cycle until B_zero, DONE presents the result.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int w = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  mult_ctrl_if.slave  bus
);

  state_t       r_state;
  state_t       w_next;
  logic         w_op_rdy;
  logic         w_res_val;
  logic         w_a_en;
  logic         w_b_en;
  logic         w_m_en;
  logic         w_b_sel;
  logic         w_m_sel;
  logic         w_clr;
  logic         w_inc;
  logic [w-1:0] w_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_op_rdy  = 1'b0;
    w_res_val = 1'b0;
    w_a_en    = 1'b0;
    w_b_en    = 1'b0;
    w_m_en    = 1'b0;
    w_b_sel   = B_SEL_IN;
    w_m_sel   = M_SEL_ZERO;
    w_clr     = 1'b0;
    w_inc     = 1'b0;
    case (r_state)
      IDLE: begin
        w_op_rdy = 1'b1;
        if (bus.operands_val) begin
          w_a_en  = 1'b1;
          w_b_en  = 1'b1;
          w_m_en  = 1'b1;
          w_clr   = 1'b1;
          // A zero multiplier skips CALC entirely; M was just cleared.
          w_next  = bus.operand_b_zero ? DONE : CALC;
        end
      end
      CALC: begin
        w_b_en  = 1'b1;
        w_m_en  = 1'b1;
        w_b_sel = B_SEL_SUB;
        w_m_sel = M_SEL_ADD;
        w_inc   = 1'b1;
        if (bus.B_zero) w_next = DONE;
      end
      DONE: begin
        w_res_val = 1'b1;
        if (bus.result_rdy) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  sat_counter #(.w(w)) u_cycles (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_inc (w_inc),
    .o_cnt (w_cnt)
  );

  // Everything is forced low while reset is asserted, so the datapath
  // stops loading immediately on a mid-operation reset.
  assign bus.operands_rdy = w_op_rdy  & rst_n;
  assign bus.result_val   = w_res_val & rst_n;
  assign bus.A_en         = w_a_en    & rst_n;
  assign bus.B_en         = w_b_en    & rst_n;
  assign bus.M_en         = w_m_en    & rst_n;
  assign bus.B_mux_sel    = w_b_sel   & rst_n;
  assign bus.M_mux_sel    = w_m_sel   & rst_n;
  assign bus.cycles       = w_cnt & {w{rst_n}};

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: a simple datapath reacts to the controller, and
// results are checked against plain a*b / latency=b expectations.
module tb_mult_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] op_a, op_b;
  logic [15:0] dp_a, dp_b, dp_m;
  int          total, bad;

  mult_ctrl_if #(.w(16)) bus ();

  mult_ctrl #(.w(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath around the controller: A, B and M registers with their muxes.
  always @(posedge clk) begin
    if (bus.A_en) dp_a <= op_a;
    if (bus.B_en) dp_b <= bus.B_mux_sel ? dp_b - 16'd1 : op_b;
    if (bus.M_en) dp_m <= bus.M_mux_sel ? dp_m + dp_a : 16'd0;
  end

  assign bus.B_zero         = (dp_b == 16'd1);
  assign bus.operand_b_zero = (op_b == 16'd0);

  function automatic logic [6:0] outs();
    return {bus.operands_rdy, bus.result_val, bus.A_en, bus.B_en, bus.M_en,
            bus.B_mux_sel, bus.M_mux_sel};
  endfunction

  // Runs one multiply, holding result_rdy low for 'hold' cycles of DONE.
  task automatic run_mult(input logic [15:0] a, input logic [15:0] b, input int hold,
                          output int lat, output int ncalc, output logic [15:0] prod,
                          output logic [15:0] cyc, output int hold_bad);
    int guard;
    guard = 0;
    while (!bus.operands_rdy && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    op_a = a; op_b = b;
    bus.operands_val = 1'b1;
    bus.result_rdy   = 1'b0;
    @(posedge clk); #1;
    bus.operands_val = 1'b0;
    lat = 0; ncalc = 0;
    while (!bus.result_val && lat < 300) begin
      if (bus.M_en && bus.M_mux_sel && !bus.A_en) ncalc++;
      @(posedge clk); #1; lat++;
    end
    prod = dp_m; cyc = bus.cycles; hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      if (!bus.result_val || dp_m !== prod || bus.cycles !== cyc ||
          outs() !== 7'b0100000) hold_bad++;
      @(posedge clk); #1;
    end
    bus.result_rdy = 1'b1;
    @(posedge clk); #1;
    bus.result_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.operands_val = 1'b1;
    bus.result_rdy = 1'b0;
    op_a = 16'd0; op_b = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (outs() !== 7'b0) begin
      bad++; $display("FAIL reset_outs: got %b exp %b", outs(), 7'b0);
    end
    total++;
    if (bus.cycles !== 16'd0) begin
      bad++; $display("FAIL reset_cycles: got %0d exp 0", bus.cycles);
    end
    bus.operands_val = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (outs() !== 7'b1000000) begin
      bad++; $display("FAIL reset_idle: got %b exp %b", outs(), 7'b1000000);
    end
  endtask

  task automatic test_basic();
    int lat, nc, hb; logic [15:0] p, c;
    run_mult(16'd3, 16'd5, 0, lat, nc, p, c, hb);
    total++; if (lat !== 5) begin bad++; $display("FAIL basic_lat: got %0d exp 5", lat); end
    total++; if (p !== 16'd15) begin bad++; $display("FAIL basic_prod: got %0d exp 15", p); end
    total++; if (c !== 16'd5) begin bad++; $display("FAIL basic_cycles: got %0d exp 5", c); end
    total++; if (nc !== 5) begin bad++; $display("FAIL basic_calc: got %0d exp 5", nc); end
    total++;
    if (outs() !== 7'b1000000) begin
      bad++; $display("FAIL basic_idle: got %b exp %b", outs(), 7'b1000000);
    end
  endtask

  task automatic test_b_zero();
    int lat, nc, hb; logic [15:0] p, c;
    run_mult(16'd7, 16'd0, 1, lat, nc, p, c, hb);
    total++; if (lat !== 0) begin bad++; $display("FAIL bzero_lat: got %0d exp 0", lat); end
    total++; if (p !== 16'd0) begin bad++; $display("FAIL bzero_prod: got %0d exp 0", p); end
    total++; if (c !== 16'd0) begin bad++; $display("FAIL bzero_cycles: got %0d exp 0", c); end
    total++; if (nc !== 0) begin bad++; $display("FAIL bzero_calc: got %0d exp 0", nc); end
  endtask

  task automatic test_wrap();
    int lat, nc, hb; logic [15:0] p, c;
    run_mult(16'hFFFF, 16'd2, 0, lat, nc, p, c, hb);
    total++; if (p !== 16'hFFFE) begin bad++; $display("FAIL wrap_prod: got %h exp fffe", p); end
    total++; if (c !== 16'd2) begin bad++; $display("FAIL wrap_cycles: got %0d exp 2", c); end
  endtask

  task automatic test_backpressure();
    int lat, nc, hb; logic [15:0] p, c;
    run_mult(16'd4, 16'd1, 3, lat, nc, p, c, hb);
    total++; if (p !== 16'd4) begin bad++; $display("FAIL bp_prod: got %0d exp 4", p); end
    total++; if (hb !== 0) begin bad++; $display("FAIL bp_hold: got %0d bad cycles exp 0", hb); end
    total++; if (lat !== 1) begin bad++; $display("FAIL bp_lat: got %0d exp 1", lat); end
    total++;
    if (outs() !== 7'b1000000) begin
      bad++; $display("FAIL bp_idle: got %b exp %b", outs(), 7'b1000000);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    op_a = 16'd2; op_b = 16'd3;
    bus.result_rdy = 1'b1;
    bus.operands_val = 1'b1;
    @(posedge clk); #1;
    n = 0;
    while (!bus.result_val && n < 50) begin @(posedge clk); #1; n++; end
    total++; if (n !== 3) begin bad++; $display("FAIL b2b_lat1: got %0d exp 3", n); end
    total++; if (dp_m !== 16'd6) begin bad++; $display("FAIL b2b_prod1: got %0d exp 6", dp_m); end
    op_a = 16'd5; op_b = 16'd4;
    @(posedge clk); #1;
    total++;
    if (outs() !== 7'b1011100) begin
      bad++; $display("FAIL b2b_idle: got %b exp %b", outs(), 7'b1011100);
    end
    @(posedge clk); #1;
    bus.operands_val = 1'b0;
    total++;
    if (bus.operands_rdy !== 1'b0) begin
      bad++; $display("FAIL b2b_accept2: got rdy %b exp 0", bus.operands_rdy);
    end
    n = 0;
    while (!bus.result_val && n < 50) begin @(posedge clk); #1; n++; end
    total++; if (n !== 4) begin bad++; $display("FAIL b2b_lat2: got %0d exp 4", n); end
    total++; if (dp_m !== 16'd20) begin bad++; $display("FAIL b2b_prod2: got %0d exp 20", dp_m); end
    @(posedge clk); #1;
    bus.result_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat, nc, hb; logic [15:0] p, c;
    op_a = 16'd9; op_b = 16'd10;
    bus.operands_val = 1'b1;
    @(posedge clk); #1;
    bus.operands_val = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    total++;
    if (outs() !== 7'b0001111 || bus.cycles !== 16'd2) begin
      bad++; $display("FAIL rstmid_calc3: got %b/%0d exp %b/2", outs(), bus.cycles, 7'b0001111);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (outs() !== 7'b0 || bus.cycles !== 16'd0) begin
      bad++; $display("FAIL rstmid_low: got %b/%0d exp 0/0", outs(), bus.cycles);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (outs() !== 7'b1000000) begin
      bad++; $display("FAIL rstmid_idle: got %b exp %b", outs(), 7'b1000000);
    end
    run_mult(16'd2, 16'd2, 0, lat, nc, p, c, hb);
    total++; if (p !== 16'd4) begin bad++; $display("FAIL rstmid_prod: got %0d exp 4", p); end
    total++; if (c !== 16'd2) begin bad++; $display("FAIL rstmid_cycles: got %0d exp 2", c); end
  endtask

  task automatic test_random();
    int lat, nc, hb; logic [15:0] p, c, a, b, exp_p;
    logic [31:0] full;
    for (int k = 0; k < 12; k++) begin
      a = 16'($urandom);
      b = 16'($urandom_range(0, 15));
      full = 32'(a) * 32'(b);
      exp_p = full[15:0];
      run_mult(a, b, $urandom_range(0, 2), lat, nc, p, c, hb);
      total++;
      if (p !== exp_p || c !== b || lat !== int'(b) || hb !== 0) begin
        bad++;
        $display("FAIL rand_%0d: %0d*%0d got p=%0d cyc=%0d lat=%0d hold_bad=%0d exp p=%0d cyc=lat=%0d",
                 k, a, b, p, c, lat, hb, exp_p, b);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_basic();
    test_b_zero();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_ctrl.md
# mult_ctrl

Control unit for the 16-bit repeated-addition multiplier. Accepts an operand pair over a val/rdy handshake and drives the multiplier datapath's register enables and mux selects. It sequences one add/decrement step per cycle until the datapath's `B_zero` flag terminates the loop, then presents the result over a second val/rdy handshake. It sits beside the datapath inside the multiplier top level, and also reports how many add cycles each multiply took.

## Interface
- `w`, 16: operand width; also the width of the cycle counter.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `operands_val`  in  1: operand pair valid.
- `operands_rdy`  out  1: controller can accept operands.
- `operand_b_zero`  in  1: combinational (`operands_bits_B == 0`) from the top level; sampled only at accept.
- `result_val`  out  1: datapath M register holds the final product.
- `result_rdy`  in  1: consumer takes the result.
- `A_en`, `B_en`, `M_en`  out  1 each: datapath register enables.
- `B_mux_sel`  out  1: 0 selects external B, 1 selects B−1.
- `M_mux_sel`  out  1: 0 selects zero, 1 selects A+M.
- `B_zero`  in  1: from datapath, high when B−1 == 0 (current B == 1).
- `cycles`  out  w: number of CALC cycles in the last or current multiply.

## Operation
- States: IDLE, CALC, DONE. A 2-bit encoded state register, reset to IDLE.
- **IDLE**
  - `operands_rdy` = 1.
  - On `operands_val`: `A_en` = `B_en` = `M_en` = 1, `B_mux_sel` = 0, `M_mux_sel` = 0. This loads A and B and clears M.
  - On the same accept, `cycles` clears to 0.
  - Next state: DONE if `operand_b_zero`, else CALC.
  - Without `operands_val`: all enables 0, stay in IDLE.
- **CALC**
  - `B_en` = `M_en` = 1, `B_mux_sel` = 1, `M_mux_sel` = 1, `A_en` = 0. Each cycle does M ← M+A and B ← B−1.
  - `cycles` increments each CALC cycle and saturates at all-ones.
  - If `B_zero` is high this cycle, go to DONE after this update; otherwise stay in CALC.
- **DONE**
  - `result_val` = 1, all enables 0; M, A and `cycles` hold.
  - On `result_rdy`: go to IDLE.
  - `operands_rdy` = 0 in DONE, so a new multiply is only accepted from IDLE.
- Output decode:
  - All enable and select outputs are combinational from state and inputs (Mealy in IDLE, Moore elsewhere).
  - Selects are 0 whenever their enable is 0.
- Arithmetic: modulo 2^w wrap is the datapath's behaviour. The controller neither checks nor flags overflow.
- Robustness: `B_zero` is ignored outside CALC, and `operand_b_zero` is ignored outside an IDLE accept.

## Timing
- Reset:
  - While `rst_n` is low, the state is IDLE and `cycles` = 0.
  - All outputs, including `operands_rdy`, are forced to 0 (gated by `rst_n`).
  - First accept is possible on the first edge after `rst_n` rises.
- Reset mid-operation (CALC or DONE): immediate return to IDLE. Enables drop combinationally; the datapath contents are don't-care.
- Latency for operand B = b ≥ 1:
  - Accept edge, then b CALC edges.
  - `result_val` rises in the cycle after the last CALC, i.e. b+1 cycles after the accept edge.
  - `cycles` = b (saturating).
- Latency for b = 0: `result_val` in the cycle after accept, M = 0, `cycles` = 0.
- `result_val` stays high and the result stays stable until the `result_rdy` edge.
- Throughput: one multiply per b+2 cycles minimum (accept, b CALC cycles, DONE with `result_rdy` already high).

## Structure
- Package `mult_pkg`:
  - `state_t` enum: IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2.
  - Mux-select constants: `B_SEL_IN`/`B_SEL_SUB`, `M_SEL_ZERO`/`M_SEL_ADD`.
- One sub-module, `sat_counter #(w)` (clear, increment, saturate, async active-low reset), for `cycles`.
- The remainder is the state register plus output decode.

## Test plan
- A = 3, B = 5, `result_rdy` held high: accepted at edge 0, `result_val` at cycle 6, product 15, `cycles` = 5.
- A = 7, B = 0 (`operand_b_zero` = 1): `result_val` next cycle, product 0, no CALC cycles, `cycles` = 0.
- A = 0xFFFF, B = 2: product 0xFFFE (wrap), `cycles` = 2, no error indication.
- A = 4, B = 1, `result_rdy` low for 3 cycles after `result_val`: `result_val` and product (4) held, `operands_rdy` = 0 throughout, IDLE on the `result_rdy` edge.
- Back-to-back pairs (2×3, then 5×4) with `operands_val` held high: products 6 then 20; second accept occurs the cycle after the first DONE handshake.
- `rst_n` pulsed low during the 3rd CALC cycle of 9×10: all enables 0 during reset, IDLE afterwards, and a following 2×2 yields 4 with `cycles` = 2.
